wave_mem_loader: RTL and testbench

//  Writer side of the 32x4 wave memory write port (write addr/data/en). Accepts a byte stream

---
 rtl/wave_mem_loader.sv | 205 ++++++++++++++++++++
 tb/tb_wave_mem_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_mem_loader.sv
// wave_mem_loader
//   Writer side of the wave memory. Takes a host byte stream of the form
//   HDR {MAGIC, start_addr}, LEN, data bytes... and unpacks each data byte
//   into two samples (low nibble first). One sample is written per cycle at
//   an auto-incrementing address that wraps modulo the memory depth.
//
//   Byte handshake: a byte is transferred on a rising clock edge where
//   byte_valid_in and byte_ready_out are both high. byte_data_in is only
//   looked at on that edge. byte_ready_out depends on the registered state
//   alone, so it never combinationally depends on byte_valid_in.
//
//   All memory-side outputs are registered. A write appears on the cycle
//   after the byte accept (low nibble) or after the WR_HI entry (high nibble).
//   Address and data hold their last value while the write strobe is low.
//
//   Header address bits are byte_data_in[ADDR_W-1:0], so ADDR_W must be at
//   most 5 to leave room for the 3-bit magic field, and DATA_W must be 4 so
//   two samples fill one byte.

module wave_mem_loader #(
  parameter int         ADDR_W  = 5,
  parameter int         DATA_W  = 4,
  parameter logic [2:0] MAGIC   = 3'b101,
  parameter int         TIMEOUT = 1023
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic              byte_valid_in,
  input  logic [7:0]        byte_data_in,
  output logic              byte_ready_out,
  output logic [ADDR_W-1:0] mem_write_addr_out,
  output logic [DATA_W-1:0] mem_write_data_out,
  output logic              mem_write_en_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  // Memory depth and the width needed to hold a sample count of 1..DEPTH.
  localparam int DEPTH = 1 << ADDR_W;
  localparam int REM_W = ADDR_W + 1;

  // Idle-cycle counter only has to reach TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [8:0]       DEPTH_9   = 9'(DEPTH);
  localparam logic [REM_W-1:0] REM_DEPTH = REM_W'(DEPTH);
  localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEN   = 2'd1,
    S_DATA  = 2'd2,
    S_WR_HI = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   ptr_q,       ptr_d;
  logic [REM_W-1:0]    rem_q,       rem_d;
  logic [DATA_W-1:0]   hold_q,      hold_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;

  logic                byte_ready;
  logic                accept;
  logic                len_saturate;

  // Ready is a pure function of the state: only the high-nibble cycle stalls the host.
  assign byte_ready   = (state_q != S_WR_HI);
  assign accept       = byte_valid_in && byte_ready;

  // LEN of zero, or anything at or beyond the depth, means a full-memory packet.
  assign len_saturate = (byte_data_in == 8'd0) || ({1'b0, byte_data_in} >= DEPTH_9);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (byte_data_in[7:5] == MAGIC) begin
            ptr_d   = byte_data_in[ADDR_W-1:0];
            state_d = S_LEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LEN: begin
        if (accept) begin
          cnt_d   = '0;
          rem_d   = len_saturate ? REM_DEPTH : REM_W'(byte_data_in);
          state_d = S_DATA;
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = byte_data_in[DATA_W-1:0];
          ptr_d     = ptr_q + 1'b1;
          rem_d     = rem_q - 1'b1;
          if (rem_q == REM_ONE) begin
            // Odd count: the high nibble of this byte is simply dropped.
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            hold_d  = byte_data_in[2*DATA_W-1:DATA_W];
            state_d = S_WR_HI;
          end
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_WR_HI: begin
        cnt_d     = '0;
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = hold_q;
        ptr_d     = ptr_q + 1'b1;
        rem_d     = rem_q - 1'b1;
        if (rem_q == REM_ONE) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any partial packet immediately.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      hold_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign byte_ready_out     = byte_ready;
  assign busy_out           = (state_q != S_IDLE);
  assign mem_write_en_out   = wr_en_q;
  assign mem_write_addr_out = wr_addr_q;
  assign mem_write_data_out = wr_data_q;
  assign done_out           = done_q;
  assign err_out            = err_q;

endmodule

// File: tb/tb_wave_mem_loader.sv
// Directed bench for wave_mem_loader: header/length/data packets, address
// wrap, odd length, bad magic, idle timeout, full-depth packet with random
// gaps, and reset in the middle of a packet.

module tb_wave_mem_loader;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 1023;
  localparam int W       = ADDR_W + DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic reset_n_in;
  always #5 clk_in = ~clk_in;

  logic              byte_valid_in;
  logic [7:0]        byte_data_in;
  logic              byte_ready_out;
  logic [ADDR_W-1:0] mem_write_addr_out;
  logic [DATA_W-1:0] mem_write_data_out;
  logic              mem_write_en_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;

  wave_mem_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MAGIC  (3'b101),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in            (clk_in),
    .reset_n_in        (reset_n_in),
    .byte_valid_in     (byte_valid_in),
    .byte_data_in      (byte_data_in),
    .byte_ready_out    (byte_ready_out),
    .mem_write_addr_out(mem_write_addr_out),
    .mem_write_data_out(mem_write_data_out),
    .mem_write_en_out  (mem_write_en_out),
    .busy_out          (busy_out),
    .done_out          (done_out),
    .err_out           (err_out)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  int           wcyc_q[$];
  logic         wrdy_q[$];
  int           extra_wr = 0;
  int           err_cnt  = 0;
  int           wr_count[32];
  logic [3:0]   mem_model[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] pk(input int addr, input int data, input bit done);
    pk = {ADDR_W'(addr), DATA_W'(data), done};
  endfunction

  function automatic logic [3:0] pat(input int a);
    pat = 4'((a * 7 + 3) & 15);
  endfunction

  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
    end
  end

  // Write monitor: every strobe is matched in order against the expected queue.
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    forever begin
      @(negedge clk_in);
      if (reset_n_in) begin
        if (mem_write_en_out) begin
          got = {mem_write_addr_out, mem_write_data_out, done_out};
          wcyc_q.push_back(cyc);
          wrdy_q.push_back(byte_ready_out);
          wr_count[mem_write_addr_out]++;
          mem_model[mem_write_addr_out] = mem_write_data_out;
          if (exp_q.size() == 0) extra_wr++;
          else begin
            e = exp_q.pop_front();
            check("wr", 32'(got), 32'(e));
          end
        end else if (done_out) begin
          extra_wr++;
        end
        if (err_out) err_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int   budget;
    logic acc;
    budget = 0;
    @(negedge clk_in);
    byte_valid_in = 1'b1;
    byte_data_in  = b;
    forever begin
      acc = byte_ready_out;
      @(posedge clk_in);
      if (acc) break;
      budget++;
      if (budget > 50) begin
        check("accept_budget", 32'(budget), 32'(0));
        break;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic idle_bus();
    @(negedge clk_in);
    byte_valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    repeat (3) @(negedge clk_in);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_extra"}, 32'(extra_wr), 32'(0));
    check({tag, "_busy"}, 32'(busy_out), 32'(0));
    exp_q.delete();
    extra_wr = 0;
  endtask

  task automatic clear_logs();
    wcyc_q.delete();
    wrdy_q.delete();
    err_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int   span;
    logic [3:0] rdy_bits;

    // 1: reset with valid held high
    reset_n_in    = 1'b0;
    byte_valid_in = 1'b1;
    byte_data_in  = 8'hA3;
    repeat (3) begin
      @(negedge clk_in);
      check("rst_en", 32'(mem_write_en_out), 32'(0));
      check("rst_busy", 32'(busy_out), 32'(0));
      check("rst_ready", 32'(byte_ready_out), 32'(1));
    end
    check("rst_done", 32'(done_out), 32'(0));
    check("rst_err", 32'(err_out), 32'(0));
    byte_valid_in = 1'b0;
    @(negedge clk_in);
    reset_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
    check("post_rst_busy", 32'(busy_out), 32'(0));
    check("post_rst_writes", 32'(wcyc_q.size()), 32'(0));
    clear_logs();

    // 2: four samples back-to-back
    exp_q.push_back(pk(3, 1, 0));
    exp_q.push_back(pk(4, 2, 0));
    exp_q.push_back(pk(5, 3, 0));
    exp_q.push_back(pk(6, 4, 1));
    send_byte(8'hA3);
    send_byte(8'h04);
    send_byte(8'h21);
    send_byte(8'h43);
    idle_bus();
    drain("t2");
    check("t2_nwr", 32'(wcyc_q.size()), 32'(4));
    if (wcyc_q.size() == 4) begin
      span = wcyc_q[3] - wcyc_q[0];
      check("t2_consecutive", 32'(span), 32'(3));
      rdy_bits = {wrdy_q[0], wrdy_q[1], wrdy_q[2], wrdy_q[3]};
      check("t2_ready_pattern", 32'(rdy_bits), 32'(4'b0101));
    end
    clear_logs();

    // 3: wrap 31 -> 0, odd length
    exp_q.push_back(pk(30, 8, 0));
    exp_q.push_back(pk(31, 9, 0));
    exp_q.push_back(pk(0, 6, 1));
    send_byte(8'hBE);
    send_byte(8'h03);
    send_byte(8'h98);
    send_byte(8'h76);
    idle_bus();
    drain("t3");
    check("t3_nwr", 32'(wcyc_q.size()), 32'(3));
    clear_logs();

    // 4: bad magic, then single-sample packet
    send_byte(8'h45);
    idle_bus();
    check("t4_err_pulse", 32'(err_out), 32'(1));
    check("t4_busy", 32'(busy_out), 32'(0));
    @(negedge clk_in);
    check("t4_err_clear", 32'(err_out), 32'(0));
    exp_q.push_back(pk(0, 15, 1));
    send_byte(8'hA0);
    send_byte(8'h01);
    send_byte(8'h0F);
    idle_bus();
    drain("t4");
    check("t4_err_cnt", 32'(err_cnt), 32'(1));
    clear_logs();

    // 5a: timeout after exactly TIMEOUT idle cycles in DATA
    send_byte(8'hA0);
    send_byte(8'h02);
    idle_bus();
    repeat (TIMEOUT - 1) @(posedge clk_in);
    @(negedge clk_in);
    check("t5_busy_before", 32'(busy_out), 32'(1));
    check("t5_err_before", 32'(err_out), 32'(0));
    @(posedge clk_in);
    @(negedge clk_in);
    check("t5_err_pulse", 32'(err_out), 32'(1));
    check("t5_busy_after", 32'(busy_out), 32'(0));
    drain("t5a");
    check("t5a_nwr", 32'(wcyc_q.size()), 32'(0));
    check("t5a_err_cnt", 32'(err_cnt), 32'(1));
    clear_logs();

    // 5b: TIMEOUT-1 idle cycles is still fine
    exp_q.push_back(pk(0, 10, 0));
    exp_q.push_back(pk(1, 5, 1));
    send_byte(8'hA0);
    send_byte(8'h02);
    idle_bus();
    repeat (TIMEOUT - 2) @(posedge clk_in);
    send_byte(8'h5A);
    idle_bus();
    drain("t5b");
    check("t5b_err_cnt", 32'(err_cnt), 32'(0));
    clear_logs();

    // 6a: full-depth packet with random gaps
    for (int a = 0; a < 32; a++) begin
      wr_count[a]  = 0;
      mem_model[a] = 4'h0;
      exp_q.push_back(pk(a, int'(pat(a)), a == 31));
    end
    send_byte(8'hA0);
    send_byte(8'h00);
    for (int i = 0; i < 16; i++) begin
      send_byte({pat(2 * i + 1), pat(2 * i)});
      if ($urandom_range(0, 1) == 1) begin
        idle_bus();
        repeat ($urandom_range(0, 4)) @(posedge clk_in);
      end
    end
    idle_bus();
    drain("t6");
    for (int a = 0; a < 32; a++) begin
      check("t6_mem", 32'(mem_model[a]), 32'(pat(a)));
      check("t6_wr_once", 32'(wr_count[a]), 32'(1));
    end
    clear_logs();

    // 6b: reset in the middle of a packet
    for (int a = 0; a < 10; a++) exp_q.push_back(pk(a, int'(pat(a)), 0));
    send_byte(8'hA0);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      send_byte({pat(2 * i + 1), pat(2 * i)});
      if (i < 4 && $urandom_range(0, 1) == 1) begin
        idle_bus();
        repeat ($urandom_range(0, 3)) @(posedge clk_in);
      end
    end
    #1;
    check("t6b_en_before", 32'(mem_write_en_out), 32'(1));
    check("t6b_busy_before", 32'(busy_out), 32'(1));
    byte_valid_in = 1'b0;
    #1;
    reset_n_in = 1'b0;
    #1;
    check("t6b_en_in_rst", 32'(mem_write_en_out), 32'(0));
    check("t6b_busy_in_rst", 32'(busy_out), 32'(0));
    check("t6b_ready_in_rst", 32'(byte_ready_out), 32'(1));
    check("t6b_pending_at_rst", 32'(exp_q.size()), 32'(2));
    exp_q.delete();
    @(negedge clk_in);
    reset_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("t6b_extra", 32'(extra_wr), 32'(0));
    clear_logs();
    exp_q.push_back(pk(5, 3, 0));
    exp_q.push_back(pk(6, 12, 1));
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hC3);
    idle_bus();
    drain("t6c");
    check("t6c_nwr", 32'(wcyc_q.size()), 32'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
